pfu_cwdscan: RTL and testbench

- Upstream sequencer for the PFU per-qubit codeword generator.
- Accepts one PFU opcode, then walks every unit cell (UC) and every qubit in that UC.
- For each UC it reads patch info from the patch-info memory and drives the generator's qbidx/ucrow/uccol/pchinfo/opcode inputs.
- Captures the generator's cwd_pf result and streams it downstream under a valid/ready handshake.

---
 rtl/pfu_cwdscan_pkg.sv | 68 ++++++
 rtl/pfu_cwdscan_if.sv | 17 +
 rtl/pfu_cwdscan_cnt.sv | 46 ++++
 rtl/pfu_cwdscan.sv | 189 ++++++++++++++++++
 tb/tb_pfu_cwdscan.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pfu_cwdscan_pkg.sv
// Shared sizing, opcode and codeword definitions for the PFU codeword scan
// sequencer (pfu_cwdscan) and its element counter.
// The backtick macros can be overridden from the command line; the package
// localparams are derived from them and are what the RTL uses.
// Optional feature macro (used by the top): PFU_CWDSCAN_PERFCNT_EN.
`ifndef NUM_UCROW
`define NUM_UCROW 2
`endif
`ifndef NUM_UCCOL
`define NUM_UCCOL 2
`endif
`ifndef QBADDR_BW
`define QBADDR_BW 2
`endif
`ifndef UCADDR_BW
`define UCADDR_BW 4
`endif
`ifndef PCHTYPE_BW
`define PCHTYPE_BW 2
`endif
`ifndef PCHDYN_BW
`define PCHDYN_BW 4
`endif
`ifndef OPCODE_BW
`define OPCODE_BW 4
`endif
`ifndef CWD_BW
`define CWD_BW 4
`endif

package pfu_cwdscan_pkg;

  localparam int unsigned NUM_UCROW  = `NUM_UCROW;
  localparam int unsigned NUM_UCCOL  = `NUM_UCCOL;
  localparam int unsigned QB_PER_UC  = 4;
  localparam int unsigned QBADDR_BW  = `QBADDR_BW;
  localparam int unsigned UCADDR_BW  = `UCADDR_BW;
  localparam int unsigned PCHTYPE_BW = `PCHTYPE_BW;
  localparam int unsigned PCHDYN_BW  = `PCHDYN_BW;
  localparam int unsigned OPCODE_BW  = `OPCODE_BW;
  localparam int unsigned CWD_BW     = `CWD_BW;
  localparam int unsigned PCHMEM_AW  = $clog2(NUM_UCROW * NUM_UCCOL);
  localparam int unsigned QBA_W      = PCHMEM_AW + QBADDR_BW;

  localparam logic [OPCODE_BW-1:0] OP_LQI        = OPCODE_BW'(1);
  localparam logic [OPCODE_BW-1:0] OP_LQM_X      = OPCODE_BW'(2);
  localparam logic [OPCODE_BW-1:0] OP_LQM_Y      = OPCODE_BW'(3);
  localparam logic [OPCODE_BW-1:0] OP_LQM_Z      = OPCODE_BW'(4);
  localparam logic [OPCODE_BW-1:0] OP_INIT_INTMD = OPCODE_BW'(5);
  localparam logic [OPCODE_BW-1:0] OP_MEAS_INTMD = OPCODE_BW'(6);

  // Idle codeword, also the reset value of the output data register
  localparam logic [CWD_BW-1:0] CWD_I = '0;

  function automatic logic op_is_scan(input logic [OPCODE_BW-1:0] op);
    case (op)
      OP_LQI, OP_LQM_X, OP_LQM_Y, OP_LQM_Z, OP_INIT_INTMD, OP_MEAS_INTMD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Row-major UC address used both for the patch memory and the output tag
  function automatic logic [PCHMEM_AW-1:0] uc_addr(input logic [UCADDR_BW-1:0] row,
                                                   input logic [UCADDR_BW-1:0] col);
    return PCHMEM_AW'(32'(row) * NUM_UCCOL + 32'(col));
  endfunction

endpackage

// File: rtl/pfu_cwdscan_if.sv
// Codeword output stream of pfu_cwdscan (valid/ready handshake).
// master: drives cwdout_valid/data/qbaddr/last, receives cwdout_ready.
// slave : the downstream consumer.
interface pfu_cwdscan_if;
  import pfu_cwdscan_pkg::*;

  logic              cwdout_valid;
  logic              cwdout_ready;
  logic [CWD_BW-1:0] cwdout_data;
  logic [QBA_W-1:0]  cwdout_qbaddr;
  logic              cwdout_last;

  modport master (output cwdout_valid, output cwdout_data, output cwdout_qbaddr,
                  output cwdout_last, input cwdout_ready);
  modport slave  (input cwdout_valid, input cwdout_data, input cwdout_qbaddr,
                  input cwdout_last, output cwdout_ready);
endinterface

// File: rtl/pfu_cwdscan_cnt.sv
// Row-major element counter for the codeword scan: ucrow outer, uccol middle,
// qbidx innermost. Holds at the final element (no wrap past the end).
// Ports: clk, rst_n (sync, active low), clr (restart at element 0),
//        adv (step one element), qb/row/col (current element),
//        last (current element is the final one).
module pfu_cwdscan_cnt
  import pfu_cwdscan_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 adv,
  output logic [QBADDR_BW-1:0] qb,
  output logic [UCADDR_BW-1:0] row,
  output logic [UCADDR_BW-1:0] col,
  output logic                 last
);

  logic qb_wrap, col_wrap, row_end;

  assign qb_wrap  = (qb  == QBADDR_BW'(QB_PER_UC - 1));
  assign col_wrap = (col == UCADDR_BW'(NUM_UCCOL - 1));
  assign row_end  = (row == UCADDR_BW'(NUM_UCROW - 1));
  assign last     = qb_wrap && col_wrap && row_end;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      qb  <= '0;
      row <= '0;
      col <= '0;
    end else if (adv && !last) begin
      if (qb_wrap) begin
        qb <= '0;
        if (col_wrap) begin
          col <= '0;
          row <= row + UCADDR_BW'(1);
        end else begin
          col <= col + UCADDR_BW'(1);
        end
      end else begin
        qb <= qb + QBADDR_BW'(1);
      end
    end
  end

endmodule

// File: rtl/pfu_cwdscan.sv
// PFU codeword scan sequencer. Accepts one opcode, walks every UC and qubit,
// reads patch info once per UC, drives the codeword generator and streams
// its cwd_pf result out through cwdout (pfu_cwdscan_if.master).
// Ports: clk, rst_n (sync, active low); instr_valid/ready/opcode (command);
//        pchmem_* (patch memory read, 1-cycle latency); qbidx..cwd_valid
//        (generator inputs), cwd_pf (generator result); cwdout (output
//        stream); scan_done (one-cycle completion pulse).
// Optional: PFU_CWDSCAN_PERFCNT_EN adds perf_busy_cyc / perf_stall_cyc.
module pfu_cwdscan
  import pfu_cwdscan_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OPCODE_BW-1:0]  instr_opcode,
  output logic                  pchmem_ren,
  output logic [PCHMEM_AW-1:0]  pchmem_raddr,
  input  logic                  pchmem_rvalid_in,
  input  logic [PCHTYPE_BW-1:0] pchmem_rtype,
  input  logic [PCHDYN_BW-1:0]  pchmem_rdyn,
  output logic [QBADDR_BW-1:0]  qbidx,
  output logic [UCADDR_BW-1:0]  ucrow,
  output logic [UCADDR_BW-1:0]  uccol,
  output logic                  pchinfo_valid,
  output logic [PCHTYPE_BW-1:0] pchtype,
  output logic [PCHDYN_BW-1:0]  pchdyn,
  output logic [OPCODE_BW-1:0]  cwd_opcode,
  output logic                  cwd_valid,
  input  logic [CWD_BW-1:0]     cwd_pf,
  pfu_cwdscan_if.master         cwdout,
  output logic                  scan_done
`ifdef PFU_CWDSCAN_PERFCNT_EN
  ,
  output logic [31:0]           perf_busy_cyc,
  output logic [31:0]           perf_stall_cyc
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic                  accept, stall, adv, issue, last_hs;
  logic [OPCODE_BW-1:0]  op_q;
  logic [QBADDR_BW-1:0]  cnt_qb;
  logic [UCADDR_BW-1:0]  cnt_row, cnt_col;
  logic                  cnt_last;

  // Issue-stage register: element whose patch read (if any) is in flight
  logic                  p0_valid, p0_rd, p0_last;
  logic [QBADDR_BW-1:0]  p0_qb;
  logic [UCADDR_BW-1:0]  p0_row, p0_col;
  logic                  s1_valid, s1_last;
  logic                  rd_pend;
  logic                  skid_valid, skid_pv;
  logic [PCHTYPE_BW-1:0] skid_type;
  logic [PCHDYN_BW-1:0]  skid_dyn;

  pfu_cwdscan_cnt u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .adv   (issue),
    .qb    (cnt_qb),
    .row   (cnt_row),
    .col   (cnt_col),
    .last  (cnt_last)
  );

  // The whole pipeline advances as one unit whenever the output register
  // is empty or being accepted.
  assign stall        = cwdout.cwdout_valid && !cwdout.cwdout_ready;
  assign adv          = !stall;
  assign instr_ready  = (state == IDLE);
  assign accept       = instr_valid && instr_ready;
  assign issue        = (state == SCAN) && adv;
  assign pchmem_ren   = issue && (cnt_qb == '0);
  assign pchmem_raddr = uc_addr(cnt_row, cnt_col);
  assign last_hs      = cwdout.cwdout_valid && cwdout.cwdout_ready && cwdout.cwdout_last;
  assign scan_done    = (state == DONE);
  assign cwd_valid    = s1_valid;
  assign cwd_opcode   = op_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = op_is_scan(instr_opcode) ? SCAN : DONE;
      SCAN:    if (issue && cnt_last) state_nx = DRAIN;
      DRAIN:   if (last_hs) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) op_q <= instr_opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_pend              <= 1'b0;
      p0_valid             <= 1'b0;
      p0_rd                <= 1'b0;
      p0_last              <= 1'b0;
      p0_qb                <= '0;
      p0_row               <= '0;
      p0_col               <= '0;
      skid_valid           <= 1'b0;
      skid_pv              <= 1'b0;
      skid_type            <= '0;
      skid_dyn             <= '0;
      s1_valid             <= 1'b0;
      s1_last              <= 1'b0;
      qbidx                <= '0;
      ucrow                <= '0;
      uccol                <= '0;
      pchinfo_valid        <= 1'b0;
      pchtype              <= '0;
      pchdyn               <= '0;
      cwdout.cwdout_valid  <= 1'b0;
      cwdout.cwdout_data   <= CWD_I;
      cwdout.cwdout_qbaddr <= '0;
      cwdout.cwdout_last   <= 1'b0;
    end else begin
      rd_pend <= pchmem_ren;

      // Read data lands while p0 holds its element; if stage 1 cannot take
      // it this cycle, park it until the pipeline moves again.
      if (rd_pend && stall) begin
        skid_valid <= 1'b1;
        skid_pv    <= pchmem_rvalid_in;
        skid_type  <= pchmem_rtype;
        skid_dyn   <= pchmem_rdyn;
      end else if (adv && p0_valid && p0_rd) begin
        skid_valid <= 1'b0;
      end

      if (adv) begin
        p0_valid <= issue;
        if (issue) begin
          p0_rd   <= (cnt_qb == '0);
          p0_last <= cnt_last;
          p0_qb   <= cnt_qb;
          p0_row  <= cnt_row;
          p0_col  <= cnt_col;
        end

        s1_valid <= p0_valid;
        if (p0_valid) begin
          s1_last <= p0_last;
          qbidx   <= p0_qb;
          ucrow   <= p0_row;
          uccol   <= p0_col;
          if (p0_rd) begin
            pchinfo_valid <= skid_valid ? skid_pv   : pchmem_rvalid_in;
            pchtype       <= skid_valid ? skid_type : pchmem_rtype;
            pchdyn        <= skid_valid ? skid_dyn  : pchmem_rdyn;
          end
        end

        cwdout.cwdout_valid <= s1_valid;
        cwdout.cwdout_last  <= s1_valid && s1_last;
        if (s1_valid) begin
          cwdout.cwdout_data   <= cwd_pf;
          cwdout.cwdout_qbaddr <= {uc_addr(ucrow, uccol), qbidx};
        end
      end
    end
  end

`ifdef PFU_CWDSCAN_PERFCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (state != IDLE && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (stall && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pfu_cwdscan.sv
// Directed self-checking bench for pfu_cwdscan with a behavioural patch
// memory (1-cycle read latency) and a behavioural codeword generator.
module tb_pfu_cwdscan;
  import pfu_cwdscan_pkg::*;

  localparam int NBEATS = NUM_UCROW * NUM_UCCOL * QB_PER_UC;

  logic                  clk;
  logic                  rst_n;
  logic                  instr_valid, instr_ready;
  logic [OPCODE_BW-1:0]  instr_opcode;
  logic                  pchmem_ren;
  logic [PCHMEM_AW-1:0]  pchmem_raddr;
  logic                  pchmem_rvalid_in;
  logic [PCHTYPE_BW-1:0] pchmem_rtype;
  logic [PCHDYN_BW-1:0]  pchmem_rdyn;
  logic [QBADDR_BW-1:0]  qbidx;
  logic [UCADDR_BW-1:0]  ucrow, uccol;
  logic                  pchinfo_valid;
  logic [PCHTYPE_BW-1:0] pchtype;
  logic [PCHDYN_BW-1:0]  pchdyn;
  logic [OPCODE_BW-1:0]  cwd_opcode;
  logic                  cwd_valid;
  logic [CWD_BW-1:0]     cwd_pf;
  logic                  scan_done;
`ifdef PFU_CWDSCAN_PERFCNT_EN
  logic [31:0]           perf_busy_cyc, perf_stall_cyc;
`endif

  pfu_cwdscan_if bus ();

  pfu_cwdscan dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_opcode     (instr_opcode),
    .pchmem_ren       (pchmem_ren),
    .pchmem_raddr     (pchmem_raddr),
    .pchmem_rvalid_in (pchmem_rvalid_in),
    .pchmem_rtype     (pchmem_rtype),
    .pchmem_rdyn      (pchmem_rdyn),
    .qbidx            (qbidx),
    .ucrow            (ucrow),
    .uccol            (uccol),
    .pchinfo_valid    (pchinfo_valid),
    .pchtype          (pchtype),
    .pchdyn           (pchdyn),
    .cwd_opcode       (cwd_opcode),
    .cwd_valid        (cwd_valid),
    .cwd_pf           (cwd_pf),
    .cwdout           (bus),
    .scan_done        (scan_done)
`ifdef PFU_CWDSCAN_PERFCNT_EN
    ,
    .perf_busy_cyc    (perf_busy_cyc),
    .perf_stall_cyc   (perf_stall_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Patch memory contents per UC address
  function automatic logic [PCHTYPE_BW-1:0] ref_type(input int a);
    case (a)
      0: return PCHTYPE_BW'(2);
      1: return PCHTYPE_BW'(1);
      2: return PCHTYPE_BW'(3);
      default: return PCHTYPE_BW'(0);
    endcase
  endfunction

  function automatic logic [PCHDYN_BW-1:0] ref_dyn(input int a);
    case (a)
      0: return PCHDYN_BW'(3);
      1: return PCHDYN_BW'(10);
      2: return PCHDYN_BW'(6);
      default: return PCHDYN_BW'(12);
    endcase
  endfunction

  function automatic logic [CWD_BW-1:0] gen(input int op, input int qb, input int row,
                                            input int col, input int typ, input int dyn);
    return CWD_BW'(op + 3 * qb + 5 * row + 7 * col + 2 * typ + dyn);
  endfunction

  // Expected codeword of beat i of a scan with opcode op
  function automatic logic [31:0] exp_data(input logic [OPCODE_BW-1:0] op, input int i);
    int uc;
    uc = i / int'(QB_PER_UC);
    return 32'(gen(int'(op), i % int'(QB_PER_UC), uc / int'(NUM_UCCOL), uc % int'(NUM_UCCOL),
                   int'(ref_type(uc)), int'(ref_dyn(uc))));
  endfunction

  // Registered memory: data only valid the cycle after ren, junk otherwise
  always @(posedge clk) begin
    if (pchmem_ren) begin
      pchmem_rvalid_in <= 1'b1;
      pchmem_rtype     <= ref_type(int'(pchmem_raddr));
      pchmem_rdyn      <= ref_dyn(int'(pchmem_raddr));
    end else begin
      pchmem_rvalid_in <= 1'b0;
      pchmem_rtype     <= '0;
      pchmem_rdyn      <= '1;
    end
  end

  always_comb begin
    cwd_pf = CWD_BW'(14);
    if (cwd_valid && pchinfo_valid)
      cwd_pf = gen(int'(cwd_opcode), int'(qbidx), int'(ucrow), int'(uccol),
                   int'(pchtype), int'(pchdyn));
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_pat(input int mode, input int k);
    case (mode)
      1: return (k % 3) == 1;
      2: return !(k == 6 || k == 7 || k == 8 || k == 12 || k == 15);
      default: return 1'b1;
    endcase
  endfunction

  int n_beats, n_reads, first_k, done_k, stall_cnt;
  int rd_q[$];

  // k counts cycles after the accepting edge (k=1 is the first one);
  // outputs are sampled 1 time unit after each falling edge.
  task automatic run_scan(input logic [OPCODE_BW-1:0] op, input int mode,
                          input int rst_beat, input bit poke);
    int k;
    bit fin, saw_done, saw_beat;
    n_beats = 0; n_reads = 0; first_k = -1; done_k = -1; stall_cnt = 0;
    rd_q.delete();
    @(negedge clk);
    instr_opcode = op;
    instr_valid  = 1'b1;
    bus.cwdout_ready = 1'b1;
    #1 chk("instr_ready_idle", 32'(instr_ready), 32'd1);
    k = 0;
    fin = 1'b0;
    while (!fin && k < 300) begin
      @(negedge clk);
      k++;
      instr_valid = poke && (k >= 4 && k <= 8);
      if (poke) instr_opcode = OP_LQM_Z;
      bus.cwdout_ready = rdy_pat(mode, k);
      #1;
      if (poke && k == 5) chk("instr_ready_busy", 32'(instr_ready), 32'd0);
      if (pchmem_ren) begin
        n_reads++;
        rd_q.push_back(int'(pchmem_raddr));
      end
      if (bus.cwdout_valid) begin
        if (first_k < 0) first_k = k;
        if (n_beats >= NBEATS) begin
          chk("beat_overrun", 32'(n_beats), 32'(NBEATS - 1));
        end else begin
          chk("beat_qbaddr", 32'(bus.cwdout_qbaddr), 32'(n_beats));
          chk("beat_data", 32'(bus.cwdout_data), exp_data(op, n_beats));
          chk("beat_last", 32'(bus.cwdout_last), 32'(n_beats == NBEATS - 1));
        end
        if (bus.cwdout_ready) n_beats++;
        else stall_cnt++;
      end
      if (scan_done) begin
        done_k = k;
        fin = 1'b1;
      end
      if (rst_beat >= 0 && bus.cwdout_valid && bus.cwdout_ready && n_beats == rst_beat + 1) begin
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_ctl", 32'({bus.cwdout_valid, bus.cwdout_last, scan_done, pchmem_ren,
                            cwd_valid, pchinfo_valid, instr_ready}), 32'd1);
        chk("rst_data", 32'({bus.cwdout_data, bus.cwdout_qbaddr, pchmem_raddr, qbidx, ucrow,
                             uccol, pchtype, pchdyn, cwd_opcode}), 32'd0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        saw_beat = 1'b0;
        repeat (25) begin
          @(negedge clk);
          #1;
          if (scan_done) saw_done = 1'b1;
          if (bus.cwdout_valid) saw_beat = 1'b1;
        end
        chk("no_activity_after_rst", 32'({saw_done, saw_beat}), 32'd0);
        fin = 1'b1;
        done_k = 0;
      end
    end
    chk("scan_timeout", 32'(fin), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr_opcode = '0;
    bus.cwdout_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", 32'({instr_ready, bus.cwdout_valid, scan_done, pchmem_ren, cwd_valid}),
        32'h10);
    rst_n = 1'b1;

    // Full-rate LQI scan
    run_scan(OP_LQI, 0, -1, 1'b0);
    chk("t1_beats", 32'(n_beats), 32'd16);
    chk("t1_first_lat", 32'(first_k), 32'd4);
    chk("t1_done_cyc", 32'(done_k), 32'd20);
    chk("t1_reads", 32'(n_reads), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t1_rd_addr", (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hFFFF, 32'(i));

    // Same scan with ready toggling 1,0,0
    run_scan(OP_LQI, 1, -1, 1'b0);
    chk("t2_beats", 32'(n_beats), 32'd16);
    chk("t2_reads", 32'(n_reads), 32'd4);
    chk("t2_done_seen", 32'(done_k > 0), 32'd1);

    // Opcode outside the scan set
    run_scan(OPCODE_BW'(11), 0, -1, 1'b0);
    chk("t3_beats", 32'(n_beats), 32'd0);
    chk("t3_reads", 32'(n_reads), 32'd0);
    chk("t3_done_cyc", 32'(done_k), 32'd1);

    // Second instruction offered mid-scan
    run_scan(OP_LQI, 0, -1, 1'b1);
    chk("t4_beats", 32'(n_beats), 32'd16);
    chk("t4_done_cyc", 32'(done_k), 32'd20);

    // Reset at beat 7, then a fresh scan
    run_scan(OP_LQM_Y, 0, 7, 1'b0);
    run_scan(OP_MEAS_INTMD, 0, -1, 1'b0);
    chk("t5_beats", 32'(n_beats), 32'd16);
    chk("t5_done_cyc", 32'(done_k), 32'd20);

    // Five stall cycles
    run_scan(OP_LQM_X, 2, -1, 1'b0);
    chk("t6_beats", 32'(n_beats), 32'd16);
    chk("t6_stalls", 32'(stall_cnt), 32'd5);
    chk("t6_done_cyc", 32'(done_k), 32'd25);
`ifdef PFU_CWDSCAN_PERFCNT_EN
    @(negedge clk);
    #1;
    chk("perf_busy", perf_busy_cyc, 32'(done_k));
    chk("perf_stall", perf_stall_cyc, 32'd5);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
